// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the program loader.
package loader_pkg;
  localparam int DEF_D       = 12;
  localparam int DEF_W       = 9;
  localparam int DEF_CW      = 32;
  localparam int DEF_TIMEOUT = 1048576;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Stream input plus instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         im_wr_en;
    logic [D-1:0] im_addr;
    logic [W-1:0] im_wr_data;

    // master: the loader; slave: the host stream source / memory side
    modport master (input  s_valid, s_data,
                    output s_ready, im_wr_en, im_addr, im_wr_data);
    modport slave  (output s_valid, s_data,
                    input  s_ready, im_wr_en, im_addr, im_wr_data);
endinterface

// File: rtl/prog_loader_sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                     cnt_d = '0;
        else if (en_i && cnt_q != '1)  cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory with the core held in reset,
// then releases the core and times its run until done or timeout.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D       = DEF_D,
    parameter int W       = DEF_W,
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [D:0]           prog_len,
    prog_loader_if.master        bus,
    output logic                 core_hold,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 finished,
    output logic                 timeout,
    output logic                 len_err,
    output logic [CW-1:0]        cycle_count
);
    localparam logic [D:0]    MAX_LEN = {1'b1, {D{1'b0}}};
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [D-1:0] ptr_q, ptr_d;
    logic [D:0]   len_q, len_d;
    logic         timeout_q, timeout_d;
    logic         len_err_q, len_err_d;
    logic         cnt_clr, cnt_en;
    logic         xfer, last, len_ok;

    assign len_ok = (prog_len != '0) && (prog_len <= MAX_LEN);
    assign xfer   = (state_q == S_LOAD) && bus.s_valid;
    assign last   = ({1'b0, ptr_q} == (len_q - (D+1)'(1)));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        timeout_d = timeout_q;
        len_err_d = len_err_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (len_ok) begin
                        len_d     = prog_len;
                        ptr_d     = '0;
                        cnt_clr   = 1'b1;
                        timeout_d = 1'b0;
                        len_err_d = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                // pointer stops on the last word so a full 2^D load never wraps
                if (xfer) begin
                    if (last) state_d = S_RELEASE;
                    else      ptr_d   = ptr_q + D'(1);
                end
            end
            S_RELEASE: state_d = S_RUN;
            S_RUN: begin
                if (core_done) begin
                    cnt_en  = 1'b1;
                    state_d = S_DONE;
                end else if (cycle_count == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins over everything; flags and count stay for the host to read
        if (abort) begin
            state_d   = S_IDLE;
            ptr_d     = ptr_q;
            len_d     = len_q;
            timeout_d = timeout_q;
            len_err_d = len_err_q;
            cnt_clr   = 1'b0;
            cnt_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            timeout_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
            len_err_q <= len_err_d;
        end
    end

    sat_counter #(.W(CW)) u_cycles (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cycle_count)
    );

    assign bus.s_ready    = (state_q == S_LOAD);
    assign bus.im_wr_en   = xfer;
    assign bus.im_addr    = ptr_q;
    assign bus.im_wr_data = bus.s_data;

    assign core_hold = !((state_q == S_RUN) || (state_q == S_DONE));
    assign busy      = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
    assign finished  = (state_q == S_DONE);
    assign timeout   = timeout_q;
    assign len_err   = len_err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, back-pressure, length errors, timeout, abort, reset.
module tb_prog_loader;
  localparam int D = 12, W = 9, CW = 32, TO = 16;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, core_done = 1'b0;
  logic [D:0]    prog_len = '0;
  logic          core_hold, busy, finished, timeout, len_err;
  logic [CW-1:0] cycle_count;
  int            n_chk = 0, n_pass = 0;
  logic [D-1:0]  log_a[$];
  logic [W-1:0]  log_d[$];

  prog_loader_if #(.D(D), .W(W)) bus ();

  prog_loader #(.D(D), .W(W), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_len(prog_len),
    .bus(bus), .core_hold(core_hold), .core_done(core_done), .busy(busy),
    .finished(finished), .timeout(timeout), .len_err(len_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // memory-side write log, sampled mid-cycle
  always @(negedge clk) if (bus.im_wr_en) begin
    log_a.push_back(bus.im_addr);
    log_d.push_back(bus.im_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [D:0] len);
    prog_len = len; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w);
    bus.s_valid = 1'b1; bus.s_data = w; #1;
    chk("send_wr_en", bus.im_wr_en, 1);
    chk("send_wr_data", bus.im_wr_data, w);
    step(); bus.s_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete();
  endtask

  initial begin
    logic [W-1:0] wv[4];
    logic [W-1:0] bp[3];
    logic         pv[6];
    int           k;
    wv = '{9'h1A0, 9'h0FF, 9'h123, 9'h001};
    bp = '{9'h055, 9'h0AA, 9'h1FF};
    pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.s_valid = 1'b0; bus.s_data = '0;

    // reset values
    #3;
    chk("rst_hold", core_hold, 1);   chk("rst_ready", bus.s_ready, 0);
    chk("rst_wr_en", bus.im_wr_en, 0); chk("rst_addr", bus.im_addr, 0);
    chk("rst_busy", busy, 0);        chk("rst_fin", finished, 0);
    chk("rst_to", timeout, 0);       chk("rst_lenerr", len_err, 0);
    chk("rst_cnt", cycle_count, 0);
    reset = 1'b1;
    step();

    // basic run: 4 words, done in 10th RUN cycle
    clear_log();
    do_start(4);
    chk("basic_ready", bus.s_ready, 1); chk("basic_hold_load", core_hold, 1);
    foreach (wv[i]) send(wv[i]);
    chk("basic_rel_ready", bus.s_ready, 0); chk("basic_rel_hold", core_hold, 1);
    chk("basic_rel_busy", busy, 1);
    step();
    chk("basic_run_hold", core_hold, 0);
    step(9);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("basic_fin", finished, 1); chk("basic_cnt", cycle_count, 10);
    chk("basic_done_hold", core_hold, 0); chk("basic_done_busy", busy, 0);
    chk("basic_nwr", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      chk("basic_addr", log_a[i], i); chk("basic_data", log_d[i], wv[i]);
    end

    // back-pressure: valid 1,0,0,1,0,1
    clear_log();
    do_start(3);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = pv[i];
      bus.s_data  = pv[i] ? bp[k] : 9'h1EE;
      #1;
      chk("bp_wr_en", bus.im_wr_en, pv[i]);
      if (pv[i]) k++;
      step();
    end
    bus.s_valid = 1'b0;
    chk("bp_rel_ready", bus.s_ready, 0);
    chk("bp_nwr", log_a.size(), 3);
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      chk("bp_addr", log_a[i], i); chk("bp_data", log_d[i], bp[i]);
    end
    step(3);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("bp_fin", finished, 1); chk("bp_cnt", cycle_count, 3);

    // restart from DONE with 2 words
    clear_log();
    do_start(2);
    chk("rs_fin", finished, 0); chk("rs_cnt", cycle_count, 0);
    chk("rs_hold", core_hold, 1); chk("rs_ready", bus.s_ready, 1);
    send(9'h0C3); send(9'h13C);
    step(5);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("rs_fin2", finished, 1); chk("rs_cnt2", cycle_count, 5);
    chk("rs_nwr", log_a.size(), 2);
    for (int i = 0; i < 2 && i < log_a.size(); i++) chk("rs_addr", log_a[i], i);

    // length errors
    clear_log();
    do_start(0);
    chk("len0_err", len_err, 1); chk("len0_hold", core_hold, 1);
    chk("len0_ready", bus.s_ready, 0); chk("len0_busy", busy, 0);
    chk("len0_fin", finished, 0);
    do_start(13'd4097);
    chk("len4097_err", len_err, 1); chk("len4097_hold", core_hold, 1);
    chk("len4097_ready", bus.s_ready, 0); chk("len4097_busy", busy, 0);
    step();
    chk("len_nwr", log_a.size(), 0);
    // 2^D is legal
    do_start(13'd4096);
    chk("len4096_err", len_err, 0); chk("len4096_ready", bus.s_ready, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("len4096_abort_ready", bus.s_ready, 0);

    // timeout after 16 RUN cycles
    do_start(1); send(9'h0AB);
    step(16);
    chk("to_pre_cnt", cycle_count, 15); chk("to_pre_flag", timeout, 0);
    chk("to_pre_hold", core_hold, 0);
    step();
    chk("to_flag", timeout, 1); chk("to_cnt", cycle_count, 15);
    chk("to_hold", core_hold, 1); chk("to_busy", busy, 0); chk("to_fin", finished, 0);

    // done coinciding with timeout cycle
    do_start(1);
    chk("co_to_clr", timeout, 0);
    send(9'h0AC);
    step(16);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("co_fin", finished, 1); chk("co_to", timeout, 0); chk("co_cnt", cycle_count, 16);

    // abort during LOAD after 2 of 5 words
    clear_log();
    do_start(5);
    send(9'h011); send(9'h022);
    abort = 1'b1; step(); abort = 1'b0;
    chk("ab_ready", bus.s_ready, 0); chk("ab_hold", core_hold, 1);
    chk("ab_busy", busy, 0); chk("ab_nwr", log_a.size(), 2);

    // async reset during RUN
    do_start(1); send(9'h033);
    step(4);
    chk("rr_cnt", cycle_count, 3); chk("rr_hold_run", core_hold, 0);
    reset = 1'b0; #1;
    chk("rr_hold", core_hold, 1); chk("rr_busy", busy, 0);
    chk("rr_cnt0", cycle_count, 0); chk("rr_ready", bus.s_ready, 0);
    chk("rr_fin", finished, 0); chk("rr_addr", bus.im_addr, 0);
    #5 reset = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream companion to the 9-bit-instruction core. Streams machine-code words over a valid/ready interface into the instruction memory, and holds the core in reset while loading.
- After loading, releases the core, counts execution cycles until the core raises done, and reports finish or timeout.
- Sits between the host/test stream source and the core's instruction memory write port and reset input.

Parameters:
- D, 12: instruction address width; matches the core program counter width.
- W, 9: machine-code word width.
- CW, 32: cycle counter width.
- TIMEOUT, 1048576: maximum run cycles before the error state is entered.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR
- abort  in  1  return to IDLE from any state
- prog_len  in  D+1  number of words to load; legal range 1..2^D
- s_valid  in  1  stream word valid
- s_data  in  W  stream machine-code word
- s_ready  out  1  loader accepts a word
- im_wr_en  out  1  instruction memory write strobe
- im_addr  out  D  instruction memory write address
- im_wr_data  out  W  instruction memory write data
- core_hold  out  1  active-high reset to the core
- core_done  in  1  done from the core; sampled only in RUN
- busy  out  1  high in LOAD, RELEASE and RUN
- finished  out  1  high in DONE
- timeout  out  1  sticky; set on run timeout
- len_err  out  1  sticky; set when prog_len is illegal at start
- cycle_count  out  CW  run cycles elapsed; frozen in DONE/ERROR

Behaviour:
- Reset values: state=IDLE, core_hold=1, s_ready=0, im_wr_en=0, im_addr=0, busy=0, finished=0, timeout=0, len_err=0, cycle_count=0.
- Reset is asynchronous active-low. Reset asserted mid-load or mid-run returns the block to IDLE immediately; partially written memory is not cleared.
- States: IDLE, LOAD, RELEASE, RUN, DONE, ERROR.
- IDLE:
  - core_hold=1.
  - On start with prog_len in 1..2^D: latch prog_len, clear the load pointer, cycle_count, timeout and len_err, then go to LOAD.
  - On start with prog_len=0 or prog_len>2^D: set len_err and go to ERROR.
- LOAD:
  - s_ready=1.
  - A transfer occurs when s_valid && s_ready. In the same cycle: im_wr_en=1, im_addr=pointer, im_wr_data=s_data. These outputs are combinational from the transfer, and the write happens at that clock edge.
  - The pointer increments after each transfer.
  - After transfer number prog_len, deassert s_ready in the next cycle and go to RELEASE.
  - Gaps in s_valid are legal.
  - The pointer never wraps: prog_len=2^D ends with the pointer at 2^D-1.
- RELEASE:
  - One cycle, core_hold=1, so the last write settles before the core starts.
  - Then go to RUN.
- RUN:
  - core_hold=0.
  - cycle_count increments every cycle and saturates at all-ones.
  - If core_done=1, go to DONE. That cycle is counted and the count then freezes.
  - Else if cycle_count reaches TIMEOUT-1, set timeout, go to ERROR and freeze the count.
  - If core_done and timeout coincide, done wins.
- DONE:
  - finished=1, core_hold=0; the core is left parked and the host reads cycle_count.
  - start begins a new load: clear flags and counter, go to LOAD with core_hold=1.
- ERROR:
  - core_hold=1.
  - start behaves as in IDLE, including length checking.
- abort overrides start in the same cycle.
  - abort in any state: next state IDLE, core_hold=1. Flags and cycle_count are preserved until the next accepted start.
- start outside IDLE, DONE and ERROR is ignored.
- core_done outside RUN is ignored.

Decomposition:
- Package loader_pkg holds:
  - state enum type, 3-bit encoding;
  - localparams for the default D, W, CW and TIMEOUT.
- One natural sub-module: sat_counter, a saturating counter with enable, synchronous clear and async active-low reset. It is used for cycle_count; the load pointer is a plain register in the FSM.

Test Plan:
- Basic run:
  - Stimulus: prog_len=4, words 0x1A0,0x0FF,0x123,0x001 with s_valid held high; core_done pulses 10 cycles after core_hold falls.
  - Response: im_addr 0..3 with matching data; s_ready low after the 4th transfer; core_hold high through RELEASE; finished=1; cycle_count=10.
- Back-pressure:
  - Stimulus: prog_len=3 with s_valid toggling 1,0,0,1,0,1.
  - Response: exactly 3 writes at addresses 0,1,2; no im_wr_en in gap cycles.
- Length errors:
  - Stimulus: prog_len=0, then prog_len=4097 with D=12.
  - Response: in both cases len_err=1, state ERROR, core_hold=1, no writes.
- Timeout:
  - Stimulus: TIMEOUT=16, core_done never asserted.
  - Response: timeout=1 after 16 RUN cycles; cycle_count=15; core_hold re-asserted.
  - Stimulus: core_done asserted on the timeout cycle.
  - Response: DONE, timeout=0.
- Abort and reset mid-operation:
  - Stimulus: abort during LOAD after 2 of 5 words.
  - Response: IDLE, core_hold=1, s_ready=0.
  - Stimulus: reset low during RUN.
  - Response: all outputs at reset values asynchronously, before the next clk edge.
- Restart from DONE:
  - Stimulus: start in DONE with prog_len=2.
  - Response: finished clears; cycle_count=0; writes at addresses 0,1; new run counted from 0.
